// File: rtl/sha256_pkg.sv
`default_nettype none
// =============================================================================
// Module : sha256_pkg -- shared constants and state encoding for the SHA-256 block controller
// Rev    : 1.0
// =============================================================================
package sha256_pkg;

    localparam int WORD_W              = 32;
    localparam int NUM_WORDS           = 8;
    localparam int HASH_W              = WORD_W * NUM_WORDS;
    localparam int BLOCK_W             = 512;
    localparam int WDOG_CYCLES_DEFAULT = 1023;
    localparam int WDOG_W              = 16;

    localparam logic [HASH_W-1:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_ACCUM = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sha256_word_adder.sv
`default_nettype none
// =============================================================================
// Module : sha256_word_adder -- eight independent mod-2^32 lane additions (combinational)
// Rev    : 1.0
// =============================================================================
module sha256_word_adder
    import sha256_pkg::*;
(
    input  logic [HASH_W-1:0] a_in,
    input  logic [HASH_W-1:0] b_in,
    output logic [HASH_W-1:0] sum
);

    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_lane
        assign sum[i*WORD_W +: WORD_W] = a_in[i*WORD_W +: WORD_W] + b_in[i*WORD_W +: WORD_W];
    end

endmodule
`default_nettype wire

// File: rtl/sha_256_block_ctrl.sv
`default_nettype none
// =============================================================================
// Module : sha_256_block_ctrl -- sequences padded blocks through a SHA-256 round core
//          and accumulates the chaining value. Optional RUN watchdog: SHA256_CTRL_WATCHDOG_EN.
// Rev    : 1.0
// =============================================================================
module sha_256_block_ctrl
    import sha256_pkg::*;
#(
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [BLOCK_W-1:0] blk_data,
    input  logic               blk_last,
    output logic               core_start,
    output logic [BLOCK_W-1:0] core_block,
    output logic [HASH_W-1:0]  core_hash_in,
    input  logic               core_done,
    input  logic [HASH_W-1:0]  core_abcdefgh,
    output logic [HASH_W-1:0]  digest,
    output logic               digest_valid,
    input  logic               digest_ack,
    output logic               busy,
    output logic [7:0]         blk_count,
    output logic               err
);

    state_e               state_q, state_d;
    logic [HASH_W-1:0]    h_q, h_d;
    logic [BLOCK_W-1:0]   block_q, block_d;
    logic                 last_q, last_d;
    logic [7:0]           count_q, count_d;
    logic [HASH_W-1:0]    w_h_sum;
    logic                 wdog_expired;

    // Legal WDOG_CYCLES range is 1..65535; the counter below is WDOG_W bits wide.
    if ((WDOG_CYCLES < 1) || (WDOG_CYCLES > 65535)) begin : g_wdog_range_bad
    end

    sha256_word_adder u_adder (
        .a_in (h_q),
        .b_in (core_abcdefgh),
        .sum  (w_h_sum)
    );

`ifdef SHA256_CTRL_WATCHDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    // Counter value k-1 in the k-th RUN cycle; cleared while the core is being started.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == ST_LOAD) begin
            wdog_d = '0;
        end else if ((state_q == ST_RUN) && !core_done) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign wdog_expired = (wdog_q == WDOG_LAST);
`else
    assign wdog_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            h_q     <= SHA256_IV;
            block_q <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            block_q <= block_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        block_d = block_q;
        last_d  = last_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (blk_valid) begin
                    block_d = blk_data;
                    last_d  = blk_last;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                // A completion in the expiry cycle still counts as success.
                if (core_done) begin
                    state_d = ST_ACCUM;
                end else if (wdog_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_ACCUM: begin
                h_d     = w_h_sum;
                count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                state_d = last_q ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                if (digest_ack) begin
                    h_d     = SHA256_IV;
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end
`ifdef SHA256_CTRL_WATCHDOG_EN
            ST_ERR: state_d = ST_ERR;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        blk_ready    = 1'b0;
        core_start   = 1'b0;
        core_hash_in = '0;
        digest       = '0;
        digest_valid = 1'b0;
        err          = 1'b0;
        case (state_q)
            ST_IDLE:  blk_ready = 1'b1;
            ST_LOAD: begin
                core_start   = 1'b1;
                core_hash_in = h_q;
            end
            ST_RUN:   core_hash_in = h_q;
            ST_ACCUM: core_hash_in = h_q;
            ST_DONE: begin
                digest       = h_q;
                digest_valid = 1'b1;
            end
`ifdef SHA256_CTRL_WATCHDOG_EN
            ST_ERR:   err = 1'b1;
`endif
            default: ;
        endcase
        core_block = block_q;
        blk_count  = count_q;
        busy       = !((state_q == ST_IDLE) && (count_q == 8'd0));
    end

endmodule
`default_nettype wire
